// File: rtl/sd_dma_sink.sv
// sd_dma_sink: Wishbone B4 slave that absorbs the SD core's DMA writes into a
// one-sector buffer, flags completion and holds off new writes until released.
`default_nettype none

module sd_dma_sink #(
    parameter logic [29:0] BASE_ADDR = 30'h0000_0000,
    parameter int          DEPTH     = 128,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [29:0]   wb_adr_i,
    input  logic [31:0]   wb_dat_w_i,
    input  logic [3:0]    wb_sel_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [31:0]   wb_dat_r_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    input  logic          release_i,
    input  logic          clr_i,
    output logic          full_o,
    output logic          sector_done_o,
    output logic [AW:0]   fill_count_o
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    localparam logic [AW:0] LAST_BEAT = (AW + 1)'(DEPTH - 1);

    logic [31:0]   mem [DEPTH];

    state_t        state_q;
    logic          ack_q;
    logic          err_q;
    logic [31:0]   dat_r_q;
    logic [31:0]   rd_data_q;
    logic          sector_done_q;
    logic [AW:0]   fill_count_q;

    logic          req;
    logic          hit;
    logic          wr_fire;
    logic [AW-1:0] idx;

    // Burst hints carry no meaning here; every beat is handled as classic.
    logic          unused_ok;
    assign unused_ok = ^{wb_cti_i, wb_bte_i};

    assign req     = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
    assign hit     = (wb_adr_i[29:AW] == BASE_ADDR[29:AW]);
    assign idx     = wb_adr_i[AW-1:0];
    assign wr_fire = req & hit & wb_we_i & (state_q == FILL);

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_fire && wb_sel_i[b]) begin
                mem[idx][8*b +: 8] <= wb_dat_w_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= FILL;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            dat_r_q       <= 32'h0;
            rd_data_q     <= 32'h0;
            sector_done_q <= 1'b0;
            fill_count_q  <= '0;
        end else begin
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            sector_done_q <= 1'b0;
            rd_data_q     <= mem[rd_addr_i];

            // Writes while FULL are simply not answered; the master keeps
            // strobing and is picked up once the buffer is released.
            if (req) begin
                if (!hit) begin
                    err_q <= 1'b1;
                end else if (!wb_we_i) begin
                    ack_q   <= 1'b1;
                    dat_r_q <= mem[idx];
                end else if (state_q == FILL) begin
                    ack_q <= 1'b1;
                end
            end

            if (clr_i) begin
                state_q      <= FILL;
                fill_count_q <= '0;
            end else if (wr_fire) begin
                if (fill_count_q == LAST_BEAT) begin
                    state_q       <= FULL;
                    fill_count_q  <= '0;
                    sector_done_q <= 1'b1;
                end else begin
                    fill_count_q <= fill_count_q + 1'b1;
                end
            end else if (state_q == FULL && release_i) begin
                state_q <= FILL;
            end
        end
    end

    assign wb_ack_o      = ack_q;
    assign wb_err_o      = err_q;
    assign wb_dat_r_o    = dat_r_q;
    assign rd_data_o     = rd_data_q;
    assign full_o        = (state_q == FULL);
    assign sector_done_o = sector_done_q;
    assign fill_count_o  = fill_count_q;

endmodule

`default_nettype wire

// File: tb/tb_sd_dma_sink.sv
// tb_sd_dma_sink: directed self-checking bench for sd_dma_sink.
`default_nettype none

module tb_sd_dma_sink;

    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [29:0]   wb_adr = '0;
    logic [31:0]   wb_dat_w = '0;
    logic [3:0]    wb_sel = '0;
    logic [2:0]    wb_cti = '0;
    logic [1:0]    wb_bte = '0;
    logic          wb_ack, wb_err;
    logic [31:0]   wb_dat_r;
    logic [AW-1:0] rd_addr = '0;
    logic [31:0]   rd_data;
    logic          release_p = 1'b0, clr = 1'b0;
    logic          full, sector_done;
    logic [AW:0]   fill_count;

    int n_pass = 0;
    int n_total = 0;

    sd_dma_sink #(.BASE_ADDR(30'h0), .DEPTH(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_cyc_i     (wb_cyc),
        .wb_stb_i     (wb_stb),
        .wb_we_i      (wb_we),
        .wb_adr_i     (wb_adr),
        .wb_dat_w_i   (wb_dat_w),
        .wb_sel_i     (wb_sel),
        .wb_cti_i     (wb_cti),
        .wb_bte_i     (wb_bte),
        .wb_ack_o     (wb_ack),
        .wb_err_o     (wb_err),
        .wb_dat_r_o   (wb_dat_r),
        .rd_addr_i    (rd_addr),
        .rd_data_o    (rd_data),
        .release_i    (release_p),
        .clr_i        (clr),
        .full_o       (full),
        .sector_done_o(sector_done),
        .fill_count_o (fill_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access and waits (bounded) for ack or err; cyc counts edges.
    task automatic wb_access(input logic we, input logic [29:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel,
                             output logic ack, output logic err,
                             output logic [31:0] rdat, output int cyc);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr;  wb_dat_w = dat; wb_sel = sel;
        cyc = 0; ack = 1'b0; err = 1'b0;
        while (!(wb_ack || wb_err) && cyc < 20) begin
            tick();
            cyc++;
        end
        ack = wb_ack; err = wb_err; rdat = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    initial begin
        logic        a, e;
        logic [31:0] rd;
        int          c;
        int          sd_seen;

        // Reset
        repeat (3) tick();
        chk("rst_ack", wb_ack, 0);
        chk("rst_err", wb_err, 0);
        chk("rst_dat_r", wb_dat_r, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_full", full, 0);
        chk("rst_sd", sector_done, 0);
        chk("rst_fill", fill_count, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ack", wb_ack, 0);

        // Fill a whole sector with data = index
        sd_seen = 0;
        for (int i = 0; i < 128; i++) begin
            wb_access(1'b1, 30'(i), 32'(i), 4'hF, a, e, rd, c);
            chk($sformatf("wr%0d_lat", i), {31'(c), a}, {31'd1, 1'b1});
            chk($sformatf("wr%0d_sd", i), sector_done, (i == 127));
            if (sector_done) sd_seen++;
            if (i == 63) chk("fill_mid", fill_count, 64);
            tick();
        end
        chk("sd_once", sd_seen, 1);
        chk("full_after_sector", full, 1);
        chk("fill_after_sector", fill_count, 0);
        chk("sd_dropped", sector_done, 0);
        rd_addr = 7'd5;
        tick();
        chk("rd_data_5", rd_data, 32'h5);

        // 129th write stalls while full
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 30'd10; wb_dat_w = 32'h1234; wb_sel = 4'hF;
        c = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (wb_ack || wb_err) c++;
        end
        chk("stall_no_ack", c, 0);
        chk("stall_full", full, 1);
        release_p = 1'b1;
        tick();
        release_p = 1'b0;
        chk("rel_full_drop", full, 0);
        chk("rel_no_ack_yet", wb_ack, 0);
        tick();
        chk("rel_ack", wb_ack, 1);
        chk("rel_fill", fill_count, 1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        chk("rel_ack_pulse", wb_ack, 0);

        // Byte-select merge over a zero word
        wb_access(1'b1, 30'd0, 32'hAABBCCDD, 4'b0101, a, e, rd, c);
        chk("sel_wr_ack", a, 1);
        tick();
        chk("sel_fill", fill_count, 2);
        wb_access(1'b0, 30'd0, 32'h0, 4'hF, a, e, rd, c);
        chk("sel_rd_lat", {31'(c), a}, {31'd1, 1'b1});
        chk("sel_rd_data", rd, 32'h00BB00DD);
        tick();
        chk("dat_r_held", wb_dat_r, 32'h00BB00DD);
        wb_access(1'b0, 30'd10, 32'h0, 4'hF, a, e, rd, c);
        chk("rd_released_word", rd, 32'h1234);
        tick();

        // Out-of-window accesses
        wb_access(1'b1, 30'd128, 32'hFFFF_FFFF, 4'hF, a, e, rd, c);
        chk("miss_wr_err", {31'(c), a, e}, {31'd1, 1'b0, 1'b1});
        tick();
        chk("miss_err_pulse", wb_err, 0);
        chk("miss_fill", fill_count, 2);
        wb_access(1'b0, 30'd128, 32'h0, 4'hF, a, e, rd, c);
        chk("miss_rd_err", {a, e}, 2'b01);
        tick();

        // clr coincident with the 128th write
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_fill", fill_count, 0);
        for (int i = 0; i < 127; i++) begin
            wb_access(1'b1, 30'(i), 32'(i), 4'hF, a, e, rd, c);
            tick();
        end
        chk("pre_clr_fill", fill_count, 127);
        rd_addr = 7'd127;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 30'd127; wb_dat_w = 32'hDEADBEEF; wb_sel = 4'hF;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        chk("clrw_ack", wb_ack, 1);
        chk("clrw_sd", sector_done, 0);
        chk("clrw_full", full, 0);
        chk("clrw_fill", fill_count, 0);
        chk("rbw_old", rd_data, 32'd127);
        tick();
        chk("rbw_new", rd_data, 32'hDEADBEEF);

        // Asynchronous reset in the middle of an access
        wb_access(1'b1, 30'd3, 32'h3, 4'hF, a, e, rd, c);
        tick();
        chk("pre_rst_fill", fill_count, 1);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 30'd4;
        tick();
        chk("pre_rst_ack", wb_ack, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_ack", wb_ack, 0);
        chk("async_fill", fill_count, 0);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_full", full, 0);
        wb_access(1'b1, 30'd4, 32'h4, 4'hF, a, e, rd, c);
        chk("post_rst_wr", a, 1);
        tick();
        chk("post_rst_fill", fill_count, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
